// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
//   Match sequencer for the pong datapath. It turns the VGA pixel counters into
//   a registered once-per-frame tick, paces the ball with a one-cycle step
//   enable every N frames, and runs the serve / point / game-over sequence that
//   owns the left and right score registers.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   H_CNT, V_CNT             VGA pixel pointers (frame tick source)
//   Button_A, Button_B       left / right player buttons (synchronised levels)
//   L_POINT, R_POINT         one-cycle score pulses from the ball FSM
//   PADDLE_HIT               one-cycle paddle reflection pulse from the ball FSM
//   BALL_STEP                one-cycle ball move enable
//   BALL_RST                 level, hold the ball at centre
//   SERVE_SIDE               0 = left serves, 1 = right serves
//   L_SCORE, R_SCORE         scores (never exceed MAX_SCORE)
//   GAME_OVER                level, match finished
//   STATE                    current FSM state, debug only
//
// Optional feature macro: PONG_SPEEDUP_EN
//   Defined   : every HITS_PER_SPEEDUP paddle hits shorten the step period by
//               one frame, saturating at STEP_FRAMES_MIN.
//   Undefined : PADDLE_HIT is ignored, step period fixed at STEP_FRAMES_INIT.
// -----------------------------------------------------------------------------
module pong_match_ctrl #(
   parameter int unsigned FRAME_LINE         = 769,
   parameter int unsigned STEP_FRAMES_INIT   = 4,
   parameter int unsigned STEP_FRAMES_MIN    = 1,
   parameter int unsigned HITS_PER_SPEEDUP   = 4,
   parameter int unsigned SERVE_DELAY_FRAMES = 60,
   parameter int unsigned POINT_HOLD_FRAMES  = 30,
   parameter int unsigned MAX_SCORE          = 9
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [10:0] H_CNT,
   input  logic [10:0] V_CNT,
   input  logic        Button_A,
   input  logic        Button_B,
   input  logic        L_POINT,
   input  logic        R_POINT,
   input  logic        PADDLE_HIT,
   output logic        BALL_STEP,
   output logic        BALL_RST,
   output logic        SERVE_SIDE,
   output logic [3:0]  L_SCORE,
   output logic [3:0]  R_SCORE,
   output logic        GAME_OVER,
   output logic [2:0]  STATE
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_SERVE_WAIT = 3'd1,
      S_PLAY       = 3'd2,
      S_POINT_HOLD = 3'd3,
      S_OVER       = 3'd4
   } state_t;

   localparam logic [10:0] LP_FRAME_LINE  = 11'(FRAME_LINE);
   localparam logic [3:0]  LP_STEP_INIT   = 4'(STEP_FRAMES_INIT);
   localparam logic [3:0]  LP_STEP_MIN    = 4'(STEP_FRAMES_MIN);
   localparam logic [3:0]  LP_MAX_SCORE   = 4'(MAX_SCORE);
   localparam logic [7:0]  LP_SERVE_DELAY = 8'(SERVE_DELAY_FRAMES);
   localparam logic [7:0]  LP_HOLD        = 8'(POINT_HOLD_FRAMES);

   state_t     r_state;
   state_t     w_next_state;
   logic       r_frame_tick;
   logic       r_btn_a_d;
   logic       r_btn_b_d;
   logic [7:0] r_delay_cnt;
   logic [7:0] r_hold_cnt;
   logic [3:0] r_step_cnt;
   logic [3:0] r_period;
   logic [3:0] r_l_score;
   logic [3:0] r_r_score;
   logic       r_serve_side;
   logic       r_ball_step;
   logic       r_ball_rst;
   logic       r_game_over;

   logic       w_start;
   logic       w_start_side;
   logic       w_serve;
   logic       w_l_pt;
   logic       w_r_pt;
   logic       w_hold_done;
   logic       w_step_due;
   logic       w_speedup;
   logic       w_btn_a_rise;
   logic       w_btn_b_rise;
   logic [3:0] w_l_inc;
   logic [3:0] w_r_inc;
   logic [3:0] w_step_inc;
   logic [7:0] w_hold_inc;

   assign w_l_inc      = r_l_score + 4'd1;
   assign w_r_inc      = r_r_score + 4'd1;
   assign w_step_inc   = r_step_cnt + 4'd1;
   assign w_hold_inc   = r_hold_cnt + 8'd1;
   // The delayed copies track the buttons in every state, so a level already
   // held when OVER is entered never looks like a fresh press.
   assign w_btn_a_rise = Button_A & ~r_btn_a_d;
   assign w_btn_b_rise = Button_B & ~r_btn_b_d;

`ifdef PONG_SPEEDUP_EN
   localparam logic [3:0] LP_HITS = 4'(HITS_PER_SPEEDUP);

   logic [3:0] r_hit_cnt;
   logic [3:0] w_hit_inc;
   logic       w_hit_ok;

   assign w_hit_inc = r_hit_cnt + 4'd1;
   // A hit in the same cycle as an accepted point belongs to a finished rally.
   assign w_hit_ok  = (r_state == S_PLAY) & PADDLE_HIT & ~L_POINT & ~R_POINT;
   assign w_speedup = w_hit_ok & (w_hit_inc >= LP_HITS);

   // Paddle hit counter: wraps every LP_HITS hits, cleared at match start.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hit_cnt <= 4'd0;
      end else if (w_start || w_speedup) begin
         r_hit_cnt <= 4'd0;
      end else if (w_hit_ok) begin
         r_hit_cnt <= w_hit_inc;
      end
   end
`else
   localparam int unsigned LP_UNUSED_HITS = HITS_PER_SPEEDUP;
   logic w_unused_hit;

   assign w_unused_hit = PADDLE_HIT;
   assign w_speedup    = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state and per-cycle control strobes.
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_start_side = 1'b0;
      w_serve      = 1'b0;
      w_l_pt       = 1'b0;
      w_r_pt       = 1'b0;
      w_hold_done  = 1'b0;
      w_step_due   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Button_A) begin
               w_next_state = S_SERVE_WAIT;
               w_start      = 1'b1;
               w_start_side = 1'b0;
            end else if (Button_B) begin
               w_next_state = S_SERVE_WAIT;
               w_start      = 1'b1;
               w_start_side = 1'b1;
            end else begin
               w_next_state = S_IDLE;
            end
         end
         S_SERVE_WAIT: begin
            if ((r_delay_cnt >= LP_SERVE_DELAY) &&
                (r_serve_side ? Button_B : Button_A)) begin
               w_next_state = S_PLAY;
               w_serve      = 1'b1;
            end else begin
               w_next_state = S_SERVE_WAIT;
            end
         end
         S_PLAY: begin
            // Points take precedence over a due step: the rally has ended.
            if (L_POINT) begin
               w_l_pt       = 1'b1;
               w_next_state = (w_l_inc >= LP_MAX_SCORE) ? S_OVER : S_POINT_HOLD;
            end else if (R_POINT) begin
               w_r_pt       = 1'b1;
               w_next_state = (w_r_inc >= LP_MAX_SCORE) ? S_OVER : S_POINT_HOLD;
            end else if (r_frame_tick && (w_step_inc >= r_period)) begin
               w_step_due   = 1'b1;
            end else begin
               w_next_state = S_PLAY;
            end
         end
         S_POINT_HOLD: begin
            if (r_frame_tick && (w_hold_inc >= LP_HOLD)) begin
               w_next_state = S_SERVE_WAIT;
               w_hold_done  = 1'b1;
            end else begin
               w_next_state = S_POINT_HOLD;
            end
         end
         S_OVER: begin
            if (w_btn_a_rise || w_btn_b_rise) begin
               w_next_state = S_IDLE;
            end else begin
               w_next_state = S_OVER;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Frame tick, button history and registered status outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_frame_tick <= 1'b0;
         r_btn_a_d    <= 1'b0;
         r_btn_b_d    <= 1'b0;
         r_ball_step  <= 1'b0;
         r_ball_rst   <= 1'b1;
         r_game_over  <= 1'b0;
      end else begin
         r_frame_tick <= (H_CNT == 11'd0) && (V_CNT == LP_FRAME_LINE);
         r_btn_a_d    <= Button_A;
         r_btn_b_d    <= Button_B;
         r_ball_step  <= w_step_due;
         r_ball_rst   <= ~((w_next_state == S_PLAY) || (w_next_state == S_POINT_HOLD));
         r_game_over  <= (w_next_state == S_OVER);
      end
   end

   // Frame counters: serve delay, point hold and ball step pacing.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_delay_cnt <= 8'd0;
         r_hold_cnt  <= 8'd0;
         r_step_cnt  <= 4'd0;
      end else begin
         if (w_start || w_hold_done) begin
            r_delay_cnt <= 8'd0;
         end else if ((r_state == S_SERVE_WAIT) && r_frame_tick &&
                      (r_delay_cnt < LP_SERVE_DELAY)) begin
            r_delay_cnt <= r_delay_cnt + 8'd1;
         end
         if (w_l_pt || w_r_pt) begin
            r_hold_cnt <= 8'd0;
         end else if ((r_state == S_POINT_HOLD) && r_frame_tick) begin
            r_hold_cnt <= w_hold_inc;
         end
         if (w_serve || w_step_due) begin
            r_step_cnt <= 4'd0;
         end else if ((r_state == S_PLAY) && r_frame_tick) begin
            r_step_cnt <= w_step_inc;
         end
      end
   end

   // Step period, scores and serving side.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_period     <= LP_STEP_INIT;
         r_l_score    <= 4'd0;
         r_r_score    <= 4'd0;
         r_serve_side <= 1'b0;
      end else begin
         if (w_start || w_serve) begin
            r_period <= LP_STEP_INIT;
         end else if (w_speedup && (r_period > LP_STEP_MIN)) begin
            r_period <= r_period - 4'd1;
         end
         if (w_start) begin
            r_l_score    <= 4'd0;
            r_r_score    <= 4'd0;
            r_serve_side <= w_start_side;
         end else if (w_l_pt) begin
            r_l_score    <= (r_l_score >= LP_MAX_SCORE) ? LP_MAX_SCORE : w_l_inc;
            r_serve_side <= 1'b1;
         end else if (w_r_pt) begin
            r_r_score    <= (r_r_score >= LP_MAX_SCORE) ? LP_MAX_SCORE : w_r_inc;
            r_serve_side <= 1'b0;
         end
      end
   end

   assign BALL_STEP  = r_ball_step;
   assign BALL_RST   = r_ball_rst;
   assign SERVE_SIDE = r_serve_side;
   assign L_SCORE    = r_l_score;
   assign R_SCORE    = r_r_score;
   assign GAME_OVER  = r_game_over;
   assign STATE      = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_match_ctrl
//   Directed sequence with randomised timing and pixel-counter noise. A frame-
//   and event-level reference model (scores, serving side, frames since the
//   last step) predicts every observable output.
// -----------------------------------------------------------------------------
module tb_pong_match_ctrl;

   localparam int FRAME_LINE = 769;
   localparam int T_INIT     = 4;
   localparam int T_MIN      = 2;
   localparam int T_HITS     = 2;
   localparam int T_DELAY    = 2;
   localparam int T_HOLD     = 3;
   localparam int T_MAX      = 3;
`ifdef PONG_SPEEDUP_EN
   localparam bit SPEED = 1'b1;
`else
   localparam bit SPEED = 1'b0;
`endif

   localparam int ST_IDLE = 0, ST_SW = 1, ST_PLAY = 2, ST_HOLD = 3, ST_OVER = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic [10:0] H_CNT, V_CNT;
   logic        Button_A, Button_B, L_POINT, R_POINT, PADDLE_HIT;
   logic        BALL_STEP, BALL_RST, SERVE_SIDE, GAME_OVER;
   logic [3:0]  L_SCORE, R_SCORE;
   logic [2:0]  STATE;

   pong_match_ctrl #(
      .FRAME_LINE(FRAME_LINE), .STEP_FRAMES_INIT(T_INIT), .STEP_FRAMES_MIN(T_MIN),
      .HITS_PER_SPEEDUP(T_HITS), .SERVE_DELAY_FRAMES(T_DELAY),
      .POINT_HOLD_FRAMES(T_HOLD), .MAX_SCORE(T_MAX)
   ) dut (
      .CLK(CLK), .RST(RST), .H_CNT(H_CNT), .V_CNT(V_CNT),
      .Button_A(Button_A), .Button_B(Button_B), .L_POINT(L_POINT),
      .R_POINT(R_POINT), .PADDLE_HIT(PADDLE_HIT), .BALL_STEP(BALL_STEP),
      .BALL_RST(BALL_RST), .SERVE_SIDE(SERVE_SIDE), .L_SCORE(L_SCORE),
      .R_SCORE(R_SCORE), .GAME_OVER(GAME_OVER), .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0, n_bad = 0;
   int step_seen = 0, step_wide = 0;
   bit prev_step = 1'b0;

   // Count ball step pulses and pulses wider than one cycle.
   always @(negedge CLK) begin
      if (BALL_STEP === 1'b1) step_seen <= step_seen + 1;
      if ((BALL_STEP === 1'b1) && prev_step) step_wide <= step_wide + 1;
      prev_step <= (BALL_STEP === 1'b1);
   end

   // Reference model (frame / event level)
   int m_st, m_l, m_r, m_side, m_go, m_period, m_phase, m_hits, m_delay, m_hold, m_steps;

   task automatic m_reset();
      m_st = ST_IDLE; m_l = 0; m_r = 0; m_side = 0; m_go = 0;
      m_period = T_INIT; m_phase = 0; m_hits = 0; m_delay = 0; m_hold = 0;
   endtask

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".state"},  STATE, m_st);
      chk({tag, ".ballrst"}, BALL_RST, ((m_st == ST_PLAY) || (m_st == ST_HOLD)) ? 0 : 1);
      chk({tag, ".side"},   SERVE_SIDE, m_side);
      chk({tag, ".lscore"}, L_SCORE, m_l);
      chk({tag, ".rscore"}, R_SCORE, m_r);
      chk({tag, ".over"},   GAME_OVER, m_go);
      chk({tag, ".steps"},  step_seen, m_steps);
      chk({tag, ".wide"},   step_wide, 0);
   endtask

   // One frame: a tick cycle, a near-miss cycle, then random non-tick noise.
   task automatic tick();
      @(negedge CLK); H_CNT = 11'd0; V_CNT = 11'(FRAME_LINE);
      @(negedge CLK); H_CNT = 11'($urandom_range(1, 1599)); V_CNT = 11'(FRAME_LINE);
      repeat ($urandom_range(2, 5)) begin
         @(negedge CLK);
         H_CNT = 11'($urandom_range(0, 1599));
         V_CNT = 11'($urandom_range(0, FRAME_LINE - 1));
      end
      case (m_st)
         ST_SW:   m_delay++;
         ST_PLAY: begin
            m_phase++;
            if (m_phase >= m_period) begin m_steps++; m_phase = 0; end
         end
         ST_HOLD: begin
            m_hold++;
            if (m_hold >= T_HOLD) begin m_st = ST_SW; m_delay = 0; end
         end
         default: ;
      endcase
   endtask

   // One-cycle button press from the released state.
   task automatic press(bit a, bit b);
      @(negedge CLK); Button_A = a; Button_B = b;
      @(negedge CLK); Button_A = 1'b0; Button_B = 1'b0;
      case (m_st)
         ST_IDLE: if (a || b) begin
            m_st = ST_SW; m_side = a ? 0 : 1; m_l = 0; m_r = 0;
            m_period = T_INIT; m_hits = 0; m_delay = 0;
         end
         ST_SW: if ((m_delay >= T_DELAY) && ((m_side == 0) ? a : b)) begin
            m_st = ST_PLAY; m_period = T_INIT; m_phase = 0;
         end
         ST_OVER: if (a || b) begin m_st = ST_IDLE; m_go = 0; end
         default: ;
      endcase
   endtask

   task automatic point(bit l, bit r);
      @(negedge CLK); L_POINT = l; R_POINT = r;
      @(negedge CLK); L_POINT = 1'b0; R_POINT = 1'b0;
      if (m_st == ST_PLAY) begin
         if (l) begin
            m_l++; m_side = 1;
            if (m_l >= T_MAX) begin m_st = ST_OVER; m_go = 1; end
            else begin m_st = ST_HOLD; m_hold = 0; end
         end else if (r) begin
            m_r++; m_side = 0;
            if (m_r >= T_MAX) begin m_st = ST_OVER; m_go = 1; end
            else begin m_st = ST_HOLD; m_hold = 0; end
         end
      end
   endtask

   task automatic hit();
      @(negedge CLK); PADDLE_HIT = 1'b1;
      @(negedge CLK); PADDLE_HIT = 1'b0;
      if ((m_st == ST_PLAY) && SPEED) begin
         m_hits++;
         if (m_hits >= T_HITS) begin
            m_hits = 0;
            if (m_period > T_MIN) m_period--;
         end
      end
   endtask

   // Random early / wrong-button presses, then serve within a bounded loop.
   task automatic serve_rally();
      repeat ($urandom_range(0, 2)) begin
         bit a;
         a = 1'($urandom_range(0, 1));
         press(a, !a);
         check_all("pre_serve");
         tick();
      end
      for (int i = 0; i < 8 && m_st != ST_PLAY; i++) begin
         tick();
         press(m_side == 0, m_side == 1);
      end
      check_all("serve");
   endtask

   task automatic play(int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if ($urandom_range(0, 2) == 0) hit();
      end
   endtask

   int base;

   initial begin
      RST = 1'b1; H_CNT = 11'd0; V_CNT = 11'd0;
      Button_A = 1'b0; Button_B = 1'b0; L_POINT = 1'b0; R_POINT = 1'b0; PADDLE_HIT = 1'b0;
      m_steps = 0;
      m_reset();
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check_all("reset");

      // Idle frames: ball held, no steps.
      repeat (10) tick();
      check_all("idle10");

      // Right player starts; early press ignored, wrong button ignored.
      press(1'b0, 1'b1);
      check_all("start_b");
      tick();
      press(1'b0, 1'b1);
      check_all("early_b");
      tick(); tick();
      press(1'b1, 1'b0);
      check_all("wrong_btn");
      press(1'b0, 1'b1);
      check_all("serve_b");

      // Fixed-period stepping: 5 steps in 20 frames.
      base = step_seen;
      repeat (20) tick();
      chk("steps20", step_seen - base, 5);
      check_all("play20");

      // Simultaneous points: left wins.
      point(1'b1, 1'b1);
      check_all("simul");
      point(1'b0, 1'b1);
      hit();
      check_all("hold_ignore");
      repeat (T_HOLD - 1) tick();
      check_all("hold_wait");
      tick();
      check_all("hold_done");

      // Right scores until one short of the match.
      for (int g = 0; g < 6 && m_r < T_MAX - 1; g++) begin
         serve_rally();
         play($urandom_range(1, 8));
         point(1'b0, 1'b1);
         check_all("rally");
         repeat (T_HOLD) tick();
      end

      // Final point with the left button already held.
      serve_rally();
      play(2);
      @(negedge CLK); Button_A = 1'b1;
      point(1'b0, 1'b1);
      repeat (3) @(negedge CLK);
      check_all("over_held");
      Button_A = 1'b0;
      repeat (2) @(negedge CLK);
      check_all("over_release");
      base = step_seen;
      repeat (5) tick();
      chk("over_nostep", step_seen - base, 0);
      press(1'b1, 1'b0);
      check_all("over_exit");
      press(1'b1, 1'b0);
      check_all("restart");

      // Paddle-hit speedup (or fixed period when the feature is absent).
      serve_rally();
      hit(); hit();
      repeat (12) tick();
      check_all("spd2");
      hit(); hit();
      repeat (12) tick();
      check_all("spd4");
      repeat (4) hit();
      repeat (12) tick();
      check_all("spd8");
      point(1'b1, 1'b0);
      repeat (T_HOLD) tick();
      serve_rally();
      repeat (12) tick();
      check_all("spd_reload");

      // Reach L_SCORE=2 in play, then reset mid-match.
      point(1'b1, 1'b0);
      repeat (T_HOLD) tick();
      serve_rally();
      play(2);
      chk("pre_rst.l", L_SCORE, 2);
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK);
      m_reset();
      chk("rst.step", BALL_STEP, 0);
      check_all("mid_rst");
      RST = 1'b0;
      repeat (2) tick();
      check_all("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
